// File: rtl/ctrl_pipe_pkg.sv
// rtl/ctrl_pipe_pkg.sv - shared constants for the decoded-control pipeline chain
package ctrl_pipe_pkg;

    localparam int DEF_W      = 32;
    localparam int DEF_STAGES = 3;

    // Stage indices in the default 3-stage core
    localparam int STG_E = 0;
    localparam int STG_M = 1;
    localparam int STG_W = 2;

    // Bit offsets of the fields inside the decoded control bundle
    localparam int OFF_MEMTOREG   = 0;
    localparam int OFF_MEMWRITE   = 1;
    localparam int OFF_ALUSRC     = 2;
    localparam int OFF_REGDST     = 3;
    localparam int OFF_REGWRITE   = 4;
    localparam int OFF_SA         = 5;
    localparam int SA_W           = 5;
    localparam int OFF_ALUCONTROL = 10;
    localparam int ALUCONTROL_W   = 5;
    localparam int OFF_HILOWRITE  = 15;
    localparam int OFF_JALR       = 16;
    localparam int OFF_JBRAL      = 17;
    localparam int OFF_CP0WE      = 18;
    localparam int OFF_CP0READ    = 19;
    localparam int OFF_ERET       = 20;
    localparam int OFF_MEMREAD    = 21;

endpackage

// File: rtl/ctrl_pipe_stage.sv
// rtl/ctrl_pipe_stage.sv - one pipeline stage register with priority logic; counters under CTRL_PIPE_STATS_EN
module ctrl_pipe_stage
    import ctrl_pipe_pkg::*;
#(
    parameter int W = DEF_W
`ifdef CTRL_PIPE_STATS_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     up_bundle,
    input  logic             up_valid,
    input  logic             stall_here,
    input  logic             stall_prev,
    input  logic             flush,
    input  logic             kill_all,
`ifdef CTRL_PIPE_STATS_EN
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt,
`endif
    output logic [W-1:0]     bundle,
    output logic             valid
);

    logic clear;
    logic bubble;

    assign clear  = kill_all | flush;
    assign bubble = ~clear & ~stall_here & stall_prev;

    // Stage register: clear, hold, bubble, or load; invalid slots always carry zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid  <= 1'b0;
            bundle <= '0;
        end else if (clear) begin
            valid  <= 1'b0;
            bundle <= '0;
        end else if (!stall_here) begin
            if (bubble) begin
                valid  <= 1'b0;
                bundle <= '0;
            end else begin
                valid  <= up_valid;
                bundle <= up_valid ? up_bundle : '0;
            end
        end
    end

`ifdef CTRL_PIPE_STATS_EN
    logic flushed_real;
    assign flushed_real = clear & valid;

    // Saturating bubble/flush counters; clear wins over increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else if (cnt_clr) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (bubble && (bubble_cnt != '1)) bubble_cnt <= bubble_cnt + 1'b1;
            if (flushed_real && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - control bundle pipeline chain with stall propagation; stats via CTRL_PIPE_STATS_EN
module ctrl_pipe
    import ctrl_pipe_pkg::*;
#(
    parameter int W      = DEF_W,
    parameter int STAGES = DEF_STAGES
`ifdef CTRL_PIPE_STATS_EN
    ,
    parameter int CNT_W  = 32
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [W-1:0]            in_bundle,
    input  logic                    in_valid,
    input  logic [STAGES-1:0]       stall,
    input  logic [STAGES-1:0]       flush,
    input  logic                    kill_all,
    output logic                    stall_up,
    output logic [STAGES*W-1:0]     out_bundle,
    output logic [STAGES-1:0]       out_valid
`ifdef CTRL_PIPE_STATS_EN
    ,
    input  logic                    cnt_clr,
    output logic [STAGES*CNT_W-1:0] bubble_cnt,
    output logic [STAGES*CNT_W-1:0] flush_cnt
`endif
);

    logic [STAGES-1:0] stall_eff;

    // A stage is effectively stalled if it or any stage downstream of it stalls
    always_comb begin
        logic acc;
        acc       = 1'b0;
        stall_eff = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            acc          = acc | stall[k];
            stall_eff[k] = acc;
        end
    end

    assign stall_up = stall_eff[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [W-1:0] up_bundle;
        logic         up_valid;
        logic         stall_prev;

        if (k == 0) begin : g_first
            assign up_bundle  = in_bundle;
            assign up_valid   = in_valid;
            assign stall_prev = 1'b0;
        end else begin : g_rest
            assign up_bundle  = out_bundle[(k-1)*W +: W];
            assign up_valid   = out_valid[k-1];
            assign stall_prev = stall_eff[k-1];
        end

        ctrl_pipe_stage #(
            .W(W)
`ifdef CTRL_PIPE_STATS_EN
            ,
            .CNT_W(CNT_W)
`endif
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .up_bundle (up_bundle),
            .up_valid  (up_valid),
            .stall_here(stall_eff[k]),
            .stall_prev(stall_prev),
            .flush     (flush[k]),
            .kill_all  (kill_all),
`ifdef CTRL_PIPE_STATS_EN
            .cnt_clr   (cnt_clr),
            .bubble_cnt(bubble_cnt[k*CNT_W +: CNT_W]),
            .flush_cnt (flush_cnt[k*CNT_W +: CNT_W]),
`endif
            .bundle    (out_bundle[k*W +: W]),
            .valid     (out_valid[k])
        );
    end

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb/tb_ctrl_pipe.sv - randomized self-checking bench for ctrl_pipe (W=8, STAGES=3; counters with CTRL_PIPE_STATS_EN)
module tb_ctrl_pipe;

    localparam int W  = 8;
    localparam int S  = 3;
    localparam int CW = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   in_bundle;
    logic           in_valid;
    logic [S-1:0]   stall;
    logic [S-1:0]   flush;
    logic           kill_all;
    logic           stall_up;
    logic [S*W-1:0] out_bundle;
    logic [S-1:0]   out_valid;
    logic           cnt_clr;
`ifdef CTRL_PIPE_STATS_EN
    logic [S*CW-1:0] bubble_cnt;
    logic [S*CW-1:0] flush_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [W-1:0] m_b [S];
    logic         m_v [S];
    int           m_bc [S];
    int           m_fc [S];

    always #5 clk = ~clk;

    ctrl_pipe #(
        .W(W),
        .STAGES(S)
`ifdef CTRL_PIPE_STATS_EN
        ,
        .CNT_W(CW)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_bundle (in_bundle),
        .in_valid  (in_valid),
        .stall     (stall),
        .flush     (flush),
        .kill_all  (kill_all),
        .stall_up  (stall_up),
        .out_bundle(out_bundle),
        .out_valid (out_valid)
`ifdef CTRL_PIPE_STATS_EN
        ,
        .cnt_clr   (cnt_clr),
        .bubble_cnt(bubble_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    task automatic model_reset();
        for (int s = 0; s < S; s++) begin
            m_b[s] = '0; m_v[s] = 1'b0; m_bc[s] = 0; m_fc[s] = 0;
        end
    endtask

    // One clock edge of the pipeline, computed from the stage rules
    task automatic model_edge();
        logic [W-1:0] nb [S];
        logic         nv [S];
        logic here, prev;
        for (int s = 0; s < S; s++) begin
            here = |(stall >> s);
            prev = (s > 0) && (|(stall >> (s - 1)));
            nb[s] = m_b[s]; nv[s] = m_v[s];
            if (kill_all || flush[s]) begin
                nb[s] = '0; nv[s] = 1'b0;
                if (m_v[s] && !cnt_clr && m_fc[s] < CMAX) m_fc[s]++;
            end else if (here) begin
            end else if (prev) begin
                nb[s] = '0; nv[s] = 1'b0;
                if (!cnt_clr && m_bc[s] < CMAX) m_bc[s]++;
            end else if (s == 0) begin
                nv[s] = in_valid; nb[s] = in_valid ? in_bundle : '0;
            end else begin
                nv[s] = m_v[s-1]; nb[s] = m_b[s-1];
            end
            if (cnt_clr) begin m_bc[s] = 0; m_fc[s] = 0; end
        end
        for (int s = 0; s < S; s++) begin m_b[s] = nb[s]; m_v[s] = nv[s]; end
    endtask

    task automatic drive(input logic [W-1:0] ib, input logic iv, input logic [S-1:0] st,
                         input logic [S-1:0] fl, input logic k, input logic cc);
        in_bundle = ib; in_valid = iv; stall = st; flush = fl; kill_all = k; cnt_clr = cc;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        drive('0, 1'b0, '0, '0, 1'b0, 1'b0);
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int s = 0; s < S; s++) begin
            n_cmp++;
            if (out_valid[s] !== 1'b0 || out_bundle[s*W +: W] !== 8'h00) begin
                n_bad++;
                $display("FAIL reset stage%0d: valid=%b bundle=%h want 0/00", s, out_valid[s], out_bundle[s*W +: W]);
            end
        end
        n_cmp++;
        if (stall_up !== 1'b0) begin n_bad++; $display("FAIL reset stall_up: got %b want 0", stall_up); end
    endtask

    task automatic test_latency();
        logic [W-1:0] seq [3];
        seq[0] = 8'hA5; seq[1] = 8'h3C; seq[2] = 8'h0F;
        do_reset();
        for (int e = 0; e < 5; e++) begin
            if (e < 3) drive(seq[e], 1'b1, '0, '0, 1'b0, 1'b0);
            else       drive('0, 1'b0, '0, '0, 1'b0, 1'b0);
            #1;
            n_cmp++;
            if (stall_up !== 1'b0) begin n_bad++; $display("FAIL latency stall_up edge%0d: got %b want 0", e, stall_up); end
            tick();
            if (e >= 2) begin
                n_cmp++;
                if (out_valid[2] !== 1'b1 || out_bundle[2*W +: W] !== seq[e-2]) begin
                    n_bad++;
                    $display("FAIL latency stage2 edge%0d: valid=%b bundle=%h want 1/%h", e + 1, out_valid[2], out_bundle[2*W +: W], seq[e-2]);
                end
            end
        end
    endtask

    task automatic load_112233();
        drive(8'h33, 1'b1, '0, '0, 1'b0, 1'b0); tick();
        drive(8'h22, 1'b1, '0, '0, 1'b0, 1'b0); tick();
        drive(8'h11, 1'b1, '0, '0, 1'b0, 1'b0); tick();
    endtask

    task automatic test_stall_bubble();
        logic [W-1:0] want_b [3];
        logic         want_v [3];
        do_reset();
        load_112233();
        drive(8'h44, 1'b1, 3'b010, '0, 1'b0, 1'b0);
        #1;
        n_cmp++;
        if (stall_up !== 1'b1) begin n_bad++; $display("FAIL stall_bubble stall_up: got %b want 1", stall_up); end
        tick();
        want_b[0] = 8'h11; want_v[0] = 1'b1;
        want_b[1] = 8'h22; want_v[1] = 1'b1;
        want_b[2] = 8'h00; want_v[2] = 1'b0;
        for (int s = 0; s < S; s++) begin
            n_cmp++;
            if (out_valid[s] !== want_v[s] || out_bundle[s*W +: W] !== want_b[s]) begin
                n_bad++;
                $display("FAIL stall_bubble stage%0d: got %b/%h want %b/%h", s, out_valid[s], out_bundle[s*W +: W], want_v[s], want_b[s]);
            end
        end
        drive(8'h44, 1'b1, '0, '0, 1'b0, 1'b0);
        tick();
        want_b[0] = 8'h44; want_b[1] = 8'h11; want_b[2] = 8'h22;
        for (int s = 0; s < S; s++) begin
            n_cmp++;
            if (out_valid[s] !== 1'b1 || out_bundle[s*W +: W] !== want_b[s]) begin
                n_bad++;
                $display("FAIL stall_resume stage%0d: got %b/%h want 1/%h", s, out_valid[s], out_bundle[s*W +: W], want_b[s]);
            end
        end
    endtask

    task automatic test_stall_flush();
        do_reset();
        load_112233();
        drive(8'h77, 1'b1, 3'b100, 3'b100, 1'b0, 1'b0);
        #1;
        n_cmp++;
        if (stall_up !== 1'b1) begin n_bad++; $display("FAIL stall_flush stall_up: got %b want 1", stall_up); end
        tick();
        n_cmp++;
        if (out_valid !== 3'b011 || out_bundle !== 24'h00_22_11) begin
            n_bad++;
            $display("FAIL stall_flush state: got %b/%h want 011/002211", out_valid, out_bundle);
        end
    endtask

    task automatic test_kill();
        do_reset();
        load_112233();
        drive(8'h99, 1'b1, '0, '0, 1'b1, 1'b0);
        #1;
        n_cmp++;
        if (stall_up !== 1'b0) begin n_bad++; $display("FAIL kill stall_up: got %b want 0", stall_up); end
        tick();
        n_cmp++;
        if (out_valid !== 3'b000 || out_bundle !== 24'h0) begin
            n_bad++;
            $display("FAIL kill state: got %b/%h want 000/000000", out_valid, out_bundle);
        end
`ifdef CTRL_PIPE_STATS_EN
        for (int s = 0; s < S; s++) begin
            n_cmp++;
            if (int'(flush_cnt[s*CW +: CW]) !== 1) begin
                n_bad++;
                $display("FAIL kill flush_cnt%0d: got %0d want 1", s, flush_cnt[s*CW +: CW]);
            end
        end
`endif
    endtask

    task automatic test_async_reset();
        do_reset();
        load_112233();
        drive(8'h66, 1'b1, 3'b111, '0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        n_cmp++;
        if (out_valid !== 3'b000 || out_bundle !== 24'h0) begin
            n_bad++;
            $display("FAIL async_reset clear: got %b/%h want 000/000000", out_valid, out_bundle);
        end
        rst = 1'b0;
        drive(8'h55, 1'b1, '0, '0, 1'b0, 1'b0);
        tick();
        n_cmp++;
        if (out_valid[0] !== 1'b1 || out_bundle[0 +: W] !== 8'h55) begin
            n_bad++;
            $display("FAIL async_reset first_load: got %b/%h want 1/55", out_valid[0], out_bundle[0 +: W]);
        end
    endtask

`ifdef CTRL_PIPE_STATS_EN
    task automatic test_stats_sat();
        do_reset();
        load_112233();
        for (int i = 0; i < 4; i++) begin
            drive(8'h12, 1'b1, 3'b001, '0, 1'b0, 1'b0);
            tick();
        end
        n_cmp++;
        if (int'(bubble_cnt[1*CW +: CW]) !== 3) begin
            n_bad++;
            $display("FAIL stats_sat bubble_cnt1: got %0d want 3", bubble_cnt[1*CW +: CW]);
        end
        drive(8'h12, 1'b1, '0, '0, 1'b0, 1'b1);
        tick();
        n_cmp++;
        if (bubble_cnt !== '0 || flush_cnt !== '0) begin
            n_bad++;
            $display("FAIL stats_clr: bubble=%h flush=%h want 0/0", bubble_cnt, flush_cnt);
        end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            logic [S-1:0] st, fl;
            for (int s = 0; s < S; s++) begin
                st[s] = ($urandom_range(0, 3) == 0);
                fl[s] = ($urandom_range(0, 9) == 0);
            end
            drive(W'($urandom), ($urandom_range(0, 3) != 0), st, fl,
                  ($urandom_range(0, 24) == 0), ($urandom_range(0, 29) == 0));
            #1;
            n_cmp++;
            if (stall_up !== (|st)) begin
                n_bad++;
                $display("FAIL random stall_up cyc%0d: got %b want %b", c, stall_up, |st);
            end
            tick();
            for (int s = 0; s < S; s++) begin
                n_cmp++;
                if (out_valid[s] !== m_v[s] || out_bundle[s*W +: W] !== m_b[s]) begin
                    n_bad++;
                    $display("FAIL random stage%0d cyc%0d: got %b/%h want %b/%h", s, c, out_valid[s], out_bundle[s*W +: W], m_v[s], m_b[s]);
                end
`ifdef CTRL_PIPE_STATS_EN
                n_cmp++;
                if (int'(bubble_cnt[s*CW +: CW]) !== m_bc[s] || int'(flush_cnt[s*CW +: CW]) !== m_fc[s]) begin
                    n_bad++;
                    $display("FAIL random cnt%0d cyc%0d: got b%0d f%0d want b%0d f%0d", s, c, bubble_cnt[s*CW +: CW], flush_cnt[s*CW +: CW], m_bc[s], m_fc[s]);
                end
`endif
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        drive('0, 1'b0, '0, '0, 1'b0, 1'b0);
        #1;
        test_reset();
        test_latency();
        test_stall_bubble();
        test_stall_flush();
        test_kill();
        test_async_reset();
`ifdef CTRL_PIPE_STATS_EN
        test_stats_sat();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Parametrised pipeline register chain for decoded control bundles. It carries a W-bit control word plus a valid bit from decode through STAGES downstream stages (E, M, W in the default 3-stage core). Each stage has its own stall and flush. The chain adds four things: backward stall propagation, automatic bubble insertion, a global kill, and optional per-stage bubble/flush counters. It replaces the hand-instantiated per-stage control flops in the decode controller.

## Interface
Parameters:
- W, 32, control bundle width in bits
- STAGES, 3, number of pipeline stages; stage 0 is the first after decode, must be ≥1
- CNT_W, 32, width of each statistics counter (used only with CTRL_PIPE_STATS_EN)

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge
- rst  in  1  reset; asynchronous and active-high; clears all state
- in_bundle  in  W  decoded control word from decode
- in_valid  in  1  decode slot holds a real instruction
- stall  in  STAGES  per-stage stall request; bit k is stage k
- flush  in  STAGES  per-stage flush request
- kill_all  in  1  exception/eret kill; flushes every stage
- stall_up  out  1  decode must hold; equals stall_eff[0]
- out_bundle  out  STAGES*W  stage k bundle at bits [k*W +: W]
- out_valid  out  STAGES  per-stage valid
- cnt_clr  in  1  synchronous clear of all counters (CTRL_PIPE_STATS_EN only)
- bubble_cnt  out  STAGES*CNT_W  per-stage bubble counters (CTRL_PIPE_STATS_EN only)
- flush_cnt  out  STAGES*CNT_W  per-stage flush counters (CTRL_PIPE_STATS_EN only)

## Operation
- Effective stall, combinational: stall_eff[STAGES-1] = stall[STAGES-1]; stall_eff[k] = stall[k] | stall_eff[k+1].
- Upstream input for stage 0 is (in_bundle, in_valid). For stage k>0 it is stage k-1's registered bundle and valid.
- Stage k next state, in priority order:
  1. kill_all or flush[k]: valid←0, bundle←0.
  2. stall_eff[k]: hold.
  3. k>0 and stall_eff[k-1]: bubble, valid←0, bundle←0.
  4. Otherwise load upstream.
- A bubble can be created only at a boundary where the upstream side is stalled and the downstream side is not.
- Loading with upstream valid=0 stores bundle=0. Invariant: out_valid[k]=0 implies out_bundle slice k is all zero.
- flush[k] together with stall[k]: flush wins. stall_eff[k-1] is still driven by stall[k], so the upstream stage holds for that cycle.
- kill_all does not affect stall_up. Decode gates its own fetch on kill.
- stall_up is combinational from stall only. It has no path from flush or kill_all.

## Timing
- Reset: every out_valid=0 and every out_bundle=0. With CTRL_PIPE_STATS_EN, all counters=0.
- Latency: with no stalls, a bundle presented at edge n appears on stage k outputs after edge n+k, i.e. k+1 edges after it is presented.
- stall and flush are sampled at the rising edge. A 1-cycle stall[k] holds stages 0..k for exactly one edge and inserts one bubble into stage k+1.
- Reset asserted mid-stall clears all stages immediately. After release, the first edge loads from in_bundle and in_valid.

## Configuration
- CTRL_PIPE_STATS_EN defined:
  - bubble_cnt[k] increments on each edge where stage k takes rule 3.
  - flush_cnt[k] increments on each edge where stage k takes rule 1 while it held valid=1.
  - Counters saturate at all-ones and do not wrap.
  - cnt_clr zeroes all counters on the next edge and has priority over increment.
- CTRL_PIPE_STATS_EN undefined: cnt_clr, bubble_cnt and flush_cnt ports are absent and no counter logic is built. Pipeline behaviour is identical in both builds.

## Structure
- Shared package ctrl_pipe_pkg holds:
  - default W and STAGES constants;
  - bundle field offsets: memtoreg, memwrite, alusrc, regdst, regwrite, sa, alucontrol, hilowrite, jalr, jbral, cp0we, cp0read, eret, memread;
  - stage index constants STG_E=0, STG_M=1, STG_W=2.
- One sub-module, ctrl_pipe_stage. It holds a single stage's register, the priority logic and, under the macro, that stage's counters. It is instantiated STAGES times in a generate loop. The stall_eff chain stays in the top module.

## Test plan
- Reset, then in_valid=1 with in_bundle=0xA5,0x3C,0x0F on consecutive edges, no stalls (W=8, STAGES=3) → 0xA5 appears at stage 2 after the 3rd edge, followed by 0x3C and 0x0F; stall_up stays 0.
- stall=3'b010 for one cycle while stages 0/1/2 hold 0x11/0x22/0x33 → stages 0 and 1 hold, stage 2 becomes valid=0/bundle=0, stall_up=1 during that cycle; the pipeline resumes on the following edge.
- stall=3'b100 and flush=3'b100 in the same cycle → stage 2 cleared, stages 0 and 1 held, stall_up=1.
- kill_all pulse with all three stages valid → all out_valid=0 and all bundles 0 after one edge; with CTRL_PIPE_STATS_EN, flush_cnt each equal 1.
- Assert rst asynchronously mid-cycle while stall=3'b111 → outputs clear before the next edge; after release, in_bundle=0x55 reaches stage 0 on the first edge.
- CTRL_PIPE_STATS_EN with CNT_W=2: force four bubbles into stage 1 → bubble_cnt[1]=3 (saturated); cnt_clr → 0 after one edge.
